m_uart_loader: RTL and testbench

- Program loader that sits directly upstream of the processor's instruction memory.
- Receives a framed program image over a UART RX line and writes each 32-bit word into instruction memory through that memory's write port.
- Holds the processor in reset (r_busy) while loading and raises r_done once a frame with a correct checksum has been received.
- Replaces the hard-coded initial memory contents in FPGA builds.

---
 rtl/m_uart_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_m_uart_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_uart_loader.sv
// rtl/m_uart_loader.sv - UART program loader writing framed 32-bit words into instruction memory
module m_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_WORDS    = 4096
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_rxd,
  output logic        r_we,
  output logic [11:0] r_addr,
  output logic [31:0] r_data,
  output logic        r_busy,
  output logic        r_done,
  output logic        r_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_BITS, R_STOP} rx_state_t;
  typedef enum logic [2:0] {S_HDR, S_CNTH, S_CNTL, S_DATA, S_SUM, S_DONE} ld_state_t;

  logic            meta_q, sync_q, prev_q;
  rx_state_t       rx_q, rx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            bv_q, bv_d;
  logic            ferr_q, ferr_d;

  ld_state_t       ld_q, ld_d;
  logic [7:0]      cnth_q, cnth_d;
  logic [15:0]     nm1_q, nm1_d;
  logic [15:0]     word_q, word_d;
  logic [1:0]      bidx_q, bidx_d;
  logic [31:0]     asm_q, asm_d;
  logic [7:0]      sum_q, sum_d;
  logic            we_q, we_d;
  logic [11:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [15:0]     n_rx;

  // Byte engine: start detected on a falling edge of the synchronised line
  always_comb begin
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    bv_d    = 1'b0;
    ferr_d  = 1'b0;
    unique case (rx_q)
      R_IDLE: begin
        if (prev_q && !sync_q) begin
          rx_d  = R_START;
          cnt_d = '0;
        end
      end
      R_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          bit_d = '0;
          rx_d  = sync_q ? R_IDLE : R_BITS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_BITS: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_d = R_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_STOP: begin
        if (cnt_q == CNT_FULL) begin
          rx_d   = R_IDLE;
          bv_d   = sync_q;
          ferr_d = !sync_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rx_d = R_IDLE;
    endcase
  end

  assign n_rx = {cnth_q, shift_q};

  always_comb begin
    ld_d   = ld_q;
    cnth_d = cnth_q;
    nm1_d  = nm1_q;
    word_d = word_q;
    bidx_d = bidx_q;
    asm_d  = asm_q;
    sum_d  = sum_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d  = err_q;
    if (ferr_q && ld_q != S_HDR && ld_q != S_DONE) begin
      // Abort keeps already-written words in memory
      err_d  = 1'b1;
      busy_d = 1'b0;
      ld_d   = S_HDR;
    end else if (bv_q) begin
      unique case (ld_q)
        S_HDR: begin
          if (shift_q == 8'hA5) begin
            err_d  = 1'b0;
            busy_d = 1'b1;
            sum_d  = '0;
            word_d = '0;
            bidx_d = '0;
            ld_d   = S_CNTH;
          end
        end
        S_CNTH: begin
          cnth_d = shift_q;
          ld_d   = S_CNTL;
        end
        S_CNTL: begin
          if (n_rx == 16'd0 || {1'b0, n_rx} > 17'(MAX_WORDS)) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
            ld_d   = S_HDR;
          end else begin
            nm1_d = n_rx - 16'd1;
            ld_d  = S_DATA;
          end
        end
        S_DATA: begin
          asm_d  = {asm_q[23:0], shift_q};
          sum_d  = sum_q + shift_q;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = word_q[11:0];
            data_d = {asm_q[23:0], shift_q};
            word_d = word_q + 16'd1;
            if (word_q == nm1_q) ld_d = S_SUM;
          end
        end
        S_SUM: begin
          busy_d = 1'b0;
          if (shift_q == sum_q) begin
            done_d = 1'b1;
            ld_d   = S_DONE;
          end else begin
            err_d = 1'b1;
            ld_d  = S_HDR;
          end
        end
        S_DONE: ;
        default: ld_d = S_HDR;
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      rx_q    <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      bv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      ld_q    <= S_HDR;
      cnth_q  <= '0;
      nm1_q   <= '0;
      word_q  <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      meta_q  <= w_rxd;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      bv_q    <= bv_d;
      ferr_q  <= ferr_d;
      ld_q    <= ld_d;
      cnth_q  <= cnth_d;
      nm1_q   <= nm1_d;
      word_q  <= word_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign r_we   = we_q;
  assign r_addr = addr_q;
  assign r_data = data_q;
  assign r_busy = busy_q;
  assign r_done = done_q;
  assign r_err  = err_q;

endmodule

// File: tb/tb_m_uart_loader.sv
// tb/tb_m_uart_loader.sv - scoreboard bench for m_uart_loader
module tb_m_uart_loader;

  localparam int CPB   = 4;
  localparam int MAXW  = 64;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_rxd = 1'b1;
  logic        r_we, r_busy, r_done, r_err;
  logic [11:0] r_addr;
  logic [31:0] r_data;

  wr_t         exp_q[$];
  logic [31:0] words_q[$];
  int          n_chk = 0;
  int          n_bad = 0;

  m_uart_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .w_rxd (w_rxd),
    .r_we  (r_we),
    .r_addr(r_addr),
    .r_data(r_data),
    .r_busy(r_busy),
    .r_done(r_done),
    .r_err (r_err)
  );

  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge w_clk) begin
    if (r_we) begin
      chk("we_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(r_addr), 32'(e.addr));
        chk("wr_data", r_data, e.data);
      end
    end
    if (r_busy && r_done) chk("busy_done_excl", 32'd1, 32'd0);
  end

  task automatic settle();
    repeat (3 * CPB) @(negedge w_clk);
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    @(negedge w_clk);
    chk("rst_we",   32'(r_we),   32'd0);
    chk("rst_addr", 32'(r_addr), 32'd0);
    chk("rst_data", r_data,      32'd0);
    chk("rst_busy", 32'(r_busy), 32'd0);
    chk("rst_done", 32'(r_done), 32'd0);
    chk("rst_err",  32'(r_err),  32'd0);
    w_rst = 1'b0;
    repeat (2) @(negedge w_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    w_rxd = 1'b0;
    repeat (CPB) @(negedge w_clk);
    for (int i = 0; i < 8; i++) begin
      w_rxd = b[i];
      repeat (CPB) @(negedge w_clk);
    end
    w_rxd = stop_ok;
    repeat (CPB) @(negedge w_clk);
    w_rxd = 1'b1;
    if (!stop_ok) repeat (2 * CPB) @(negedge w_clk);
  endtask

  // Sends words_q as one frame; expected writes are queued as each word goes out
  task automatic send_frame(input bit hdr, input bit bad_sum);
    logic [7:0]  sum;
    logic [15:0] n;
    logic [31:0] w;
    n   = 16'(words_q.size());
    sum = 8'd0;
    if (hdr) send_byte(8'hA5);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int k = 0; k < words_q.size(); k++) begin
      w = words_q[k];
      exp_q.push_back({12'(k), w});
      for (int b = 3; b >= 0; b--) begin
        sum = sum + w[8*b +: 8];
        send_byte(w[8*b +: 8]);
      end
    end
    send_byte(bad_sum ? sum + 8'd1 : sum);
    settle();
  endtask

  task automatic load_two();
    words_q.delete();
    words_q.push_back(32'h0000_0001);
    words_q.push_back(32'h1234_5678);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge w_clk);
    do_reset();

    // good frame
    load_two();
    send_frame(1'b1, 1'b0);
    chk("good_done", 32'(r_done), 32'd1);
    chk("good_busy", 32'(r_busy), 32'd0);
    chk("good_err",  32'(r_err),  32'd0);
    chk("good_hold_addr", 32'(r_addr), 32'd1);
    chk("good_hold_data", r_data, 32'h1234_5678);
    chk("good_left", 32'(exp_q.size()), 32'd0);

    // bad checksum, then recovery without reset
    do_reset();
    send_frame(1'b1, 1'b1);
    chk("badsum_err",  32'(r_err),  32'd1);
    chk("badsum_busy", 32'(r_busy), 32'd0);
    chk("badsum_done", 32'(r_done), 32'd0);
    send_byte(8'hA5);
    settle();
    chk("hdr_busy", 32'(r_busy), 32'd1);
    chk("hdr_err_clr", 32'(r_err), 32'd0);
    send_frame(1'b0, 1'b0);
    chk("recover_done", 32'(r_done), 32'd1);
    chk("recover_err",  32'(r_err),  32'd0);
    chk("recover_left", 32'(exp_q.size()), 32'd0);

    // count bounds
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    settle();
    chk("n0_err",  32'(r_err),  32'd1);
    chk("n0_busy", 32'(r_busy), 32'd0);
    send_byte(8'hA5);
    settle();
    chk("nbig_hdr_err", 32'(r_err), 32'd0);
    send_byte(8'h00); send_byte(8'(MAXW + 1));
    settle();
    chk("nbig_err",  32'(r_err),  32'd1);
    chk("nbig_busy", 32'(r_busy), 32'd0);

    // glitch inside the count field must not create a byte
    do_reset();
    send_byte(8'hA5);
    w_rxd = 1'b0;
    @(negedge w_clk);
    w_rxd = 1'b1;
    repeat (2 * CPB) @(negedge w_clk);
    chk("glitch_err", 32'(r_err), 32'd0);
    load_two();
    send_frame(1'b0, 1'b0);
    chk("glitch_done", 32'(r_done), 32'd1);

    // framing error in the data field
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h55, 1'b0);
    settle();
    chk("ferr_err",  32'(r_err),  32'd1);
    chk("ferr_busy", 32'(r_busy), 32'd0);
    send_frame(1'b1, 1'b0);
    chk("ferr_recover_done", 32'(r_done), 32'd1);

    // reset after the 2nd data byte, then a fresh frame from addr 0
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hDE); send_byte(8'hAD);
    chk("mid_busy", 32'(r_busy), 32'd1);
    do_reset();
    words_q.delete();
    words_q.push_back(32'hCAFE_F00D);
    words_q.push_back(32'h0BAD_BEEF);
    send_frame(1'b1, 1'b0);
    chk("mid_done", 32'(r_done), 32'd1);
    chk("mid_left", 32'(exp_q.size()), 32'd0);

    // maximum frame, then traffic after completion
    do_reset();
    words_q.delete();
    for (int k = 0; k < MAXW; k++) words_q.push_back($urandom);
    send_frame(1'b1, 1'b0);
    chk("max_done", 32'(r_done), 32'd1);
    chk("max_last_addr", 32'(r_addr), 32'(MAXW - 1));
    chk("max_left", 32'(exp_q.size()), 32'd0);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'hAA);
    settle();
    chk("post_done", 32'(r_done), 32'd1);
    chk("post_busy", 32'(r_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
